// File: rtl/min_os_tx_scheduler_pkg.sv
// Shared constants and types for the MinOS UART transmit scheduler:
// frame bytes, interface identifiers and serializer state encoding.
package min_os_tx_scheduler_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam logic [7:0] ID_LEDS_DEF    = 8'h01;
    localparam logic [7:0] ID_DISPLAY_DEF = 8'h02;
    localparam logic [7:0] ID_ACK_DEF     = 8'h03;

    // SYNC + ID + LEN + CSUM wrapped around every payload
    localparam int FRAME_OVERHEAD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ID,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } ser_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_LEDS,
        GRANT_DISPLAY,
        GRANT_ACK
    } grant_e;

endpackage

// File: rtl/min_os_tx_scheduler_serializer.sv
// Frame serializer: emits SYNC, ID, LEN, payload and XOR checksum over a
// valid/ready byte stream, advancing one field per accepted byte.
module min_os_frame_serializer
    import min_os_tx_scheduler_pkg::*;
#(
    parameter int         DISPLAY_BYTES = 64,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       start,
    input  logic [7:0]                 id,
    input  logic [6:0]                 len,
    input  logic [8*DISPLAY_BYTES-1:0] payload,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done
);

    ser_state_e state_q, state_d;
    logic [7:0] id_q, id_d;
    logic [6:0] len_q, len_d;
    logic [6:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] payload_byte;

    always_comb begin
        payload_byte = 8'h00;
        for (int k = 0; k < DISPLAY_BYTES; k++) begin
            if (idx_q == 7'(k)) begin
                payload_byte = payload[k*8 +: 8];
            end
        end
    end

    // tx_data is a pure function of registered state, so it holds while stalled
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        len_d    = len_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SYNC;
                    id_d    = id;
                    len_d   = len;
                    idx_d   = 7'd0;
                    csum_d  = id ^ {1'b0, len};
                end
            end
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) state_d = ST_ID;
            end
            ST_ID: begin
                tx_valid = 1'b1;
                tx_data  = id_q;
                if (tx_ready) state_d = ST_LEN;
            end
            ST_LEN: begin
                tx_valid = 1'b1;
                tx_data  = {1'b0, len_q};
                if (tx_ready) state_d = (len_q == 7'd0) ? ST_CSUM : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte;
                if (tx_ready) begin
                    csum_d = csum_q ^ payload_byte;
                    if (idx_q == len_q - 7'd1) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            id_q    <= 8'h00;
            len_q   <= 7'd0;
            idx_q   <= 7'd0;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: rtl/min_os_tx_scheduler.sv
// Shares the MinOS UART transmitter between the leds, display and ACK sources:
// tracks pending changes, periodic refresh, arbitration and payload snapshots.
module min_os_tx_scheduler
    import min_os_tx_scheduler_pkg::*;
#(
    parameter int          DISPLAY_BYTES = 64,
    parameter logic [31:0] REFRESH_TICKS = 32'd100000000,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter logic [7:0]  ID_LEDS       = ID_LEDS_DEF,
    parameter logic [7:0]  ID_DISPLAY    = ID_DISPLAY_DEF,
    parameter logic [7:0]  ID_ACK        = ID_ACK_DEF
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [7:0]                 leds,
    input  logic [8*DISPLAY_BYTES-1:0] display,
    input  logic                       ack_req,
    input  logic [7:0]                 ack_code,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic [15:0]                frames_sent
);

    localparam int         PW       = 8 * DISPLAY_BYTES;
    localparam logic [6:0] DISP_LEN = 7'(DISPLAY_BYTES);

    grant_e      grant;
    logic        leds_pend_q, leds_pend_d;
    logic        disp_pend_q, disp_pend_d;
    logic        ack_pend_q, ack_pend_d;
    logic [7:0]  ack_code_q, ack_code_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  last_leds_q, last_leds_d;
    logic [PW-1:0] last_display_q, last_display_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic        rr_q, rr_d;
    logic [15:0] frames_q, frames_d;
    logic        refresh_wrap;
    logic        start;
    logic [7:0]  start_id;
    logic [6:0]  start_len;
    logic        done;

    // Compare against the post-grant last_* value so a granted source is not
    // immediately re-pended by the very change it is now sending.
    always_comb begin
        refresh_wrap   = (timer_q == REFRESH_TICKS - 32'd1);
        timer_d        = refresh_wrap ? 32'd0 : timer_q + 32'd1;
        grant          = GRANT_NONE;
        shadow_d       = shadow_q;
        last_leds_d    = last_leds_q;
        last_display_d = last_display_q;
        rr_d           = rr_q;
        ack_code_d     = ack_req ? ack_code : ack_code_q;
        start          = 1'b0;
        start_id       = ID_LEDS;
        start_len      = 7'd1;

        if (!busy) begin
            if (ack_pend_q)                grant = GRANT_ACK;
            else if (!rr_q && leds_pend_q) grant = GRANT_LEDS;
            else if (disp_pend_q)          grant = GRANT_DISPLAY;
            else if (leds_pend_q)          grant = GRANT_LEDS;
        end

        case (grant)
            GRANT_LEDS: begin
                start         = 1'b1;
                start_id      = ID_LEDS;
                start_len     = 7'd1;
                shadow_d      = '0;
                shadow_d[7:0] = leds;
                last_leds_d   = leds;
                rr_d          = 1'b1;
            end
            GRANT_DISPLAY: begin
                start          = 1'b1;
                start_id       = ID_DISPLAY;
                start_len      = DISP_LEN;
                shadow_d       = display;
                last_display_d = display;
                rr_d           = 1'b0;
            end
            GRANT_ACK: begin
                start         = 1'b1;
                start_id      = ID_ACK;
                start_len     = 7'd1;
                shadow_d      = '0;
                shadow_d[7:0] = ack_code_q;
            end
            default: ;
        endcase

        leds_pend_d = (leds_pend_q && grant != GRANT_LEDS) || (leds != last_leds_d) || refresh_wrap;
        disp_pend_d = (disp_pend_q && grant != GRANT_DISPLAY) || (display != last_display_d) || refresh_wrap;
        ack_pend_d  = (ack_pend_q && grant != GRANT_ACK) || ack_req;
        frames_d    = frames_q + {15'd0, done};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            leds_pend_q    <= 1'b0;
            disp_pend_q    <= 1'b0;
            ack_pend_q     <= 1'b0;
            ack_code_q     <= 8'h00;
            timer_q        <= 32'd0;
            last_leds_q    <= 8'h00;
            last_display_q <= '0;
            shadow_q       <= '0;
            rr_q           <= 1'b0;
            frames_q       <= 16'd0;
        end else begin
            leds_pend_q    <= leds_pend_d;
            disp_pend_q    <= disp_pend_d;
            ack_pend_q     <= ack_pend_d;
            ack_code_q     <= ack_code_d;
            timer_q        <= timer_d;
            last_leds_q    <= last_leds_d;
            last_display_q <= last_display_d;
            shadow_q       <= shadow_d;
            rr_q           <= rr_d;
            frames_q       <= frames_d;
        end
    end

    assign frames_sent = frames_q;

    min_os_frame_serializer #(
        .DISPLAY_BYTES (DISPLAY_BYTES),
        .SYNC_BYTE     (SYNC_BYTE)
    ) u_serializer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .id       (start_id),
        .len      (start_len),
        .payload  (shadow_q),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

endmodule

// File: tb/tb_min_os_tx_scheduler.sv
// Self-checking bench for min_os_tx_scheduler: directed frames plus random
// traffic compared against a frame-level reference model of the scheduler.
module tb_min_os_tx_scheduler;
    import min_os_tx_scheduler_pkg::*;

    localparam int          DB      = 64;
    localparam int          PW      = 8 * DB;
    localparam logic [31:0] REFRESH = 32'd400;

    logic          CLK;
    logic          RST_N;
    logic [7:0]    leds;
    logic [PW-1:0] display;
    logic          ack_req;
    logic [7:0]    ack_code;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic [15:0]   frames_sent;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    m_last_leds;
    logic [PW-1:0] m_last_disp;
    bit            m_leds_pend, m_disp_pend, m_ack_pend, m_rr;
    logic [7:0]    m_ack_code;
    int unsigned   m_timer;
    logic [15:0]   m_frames;
    logic [7:0]    m_cur_id;
    logic [7:0]    m_exp[$];
    logic [7:0]    tx_log[$];

    min_os_tx_scheduler #(
        .DISPLAY_BYTES (DB),
        .REFRESH_TICKS (REFRESH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .leds        (leds),
        .display     (display),
        .ack_req     (ack_req),
        .ack_code    (ack_code),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        m_last_leds = 8'h00;
        m_last_disp = '0;
        m_leds_pend = 1'b0;
        m_disp_pend = 1'b0;
        m_ack_pend  = 1'b0;
        m_rr        = 1'b0;
        m_ack_code  = 8'h00;
        m_timer     = 0;
        m_frames    = 16'd0;
        m_cur_id    = 8'h00;
        m_exp.delete();
    endfunction

    function automatic void push_frame(input logic [7:0] id, input int len, input logic [PW-1:0] pl);
        logic [7:0] cs;
        logic [7:0] b;
        cs = id ^ 8'(len);
        m_exp.push_back(SYNC_BYTE_DEF);
        m_exp.push_back(id);
        m_exp.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            b = pl[k*8 +: 8];
            cs ^= b;
            m_exp.push_back(b);
        end
        m_exp.push_back(cs);
        m_cur_id = id;
    endfunction

    // One clock edge of the scheduler seen as whole frames queued as byte lists
    function automatic void model_step();
        bit            wrap;
        int            grant;
        logic [PW-1:0] pl;
        wrap  = (m_timer == REFRESH - 1);
        grant = 0;
        if (m_exp.size() == 0) begin
            if (m_ack_pend)                grant = 3;
            else if (!m_rr && m_leds_pend) grant = 1;
            else if (m_disp_pend)          grant = 2;
            else if (m_leds_pend)          grant = 1;
        end else if (tx_ready) begin
            void'(m_exp.pop_front());
            if (m_exp.size() == 0) m_frames++;
        end
        if (grant == 1) begin
            pl = '0;
            pl[7:0] = leds;
            push_frame(ID_LEDS_DEF, 1, pl);
            m_last_leds = leds;
            m_rr        = 1'b1;
            m_leds_pend = 1'b0;
        end
        if (grant == 2) begin
            push_frame(ID_DISPLAY_DEF, DB, display);
            m_last_disp = display;
            m_rr        = 1'b0;
            m_disp_pend = 1'b0;
        end
        if (grant == 3) begin
            pl = '0;
            pl[7:0] = m_ack_code;
            push_frame(ID_ACK_DEF, 1, pl);
            m_ack_pend = 1'b0;
        end
        if (leds != m_last_leds || wrap) m_leds_pend = 1'b1;
        if (display != m_last_disp || wrap) m_disp_pend = 1'b1;
        if (ack_req) begin
            m_ack_pend = 1'b1;
            m_ack_code = ack_code;
        end
        m_timer = wrap ? 0 : m_timer + 1;
    endfunction

    // Inputs are set at a negedge; this commits them through one rising edge
    task automatic applyStimulus();
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        model_step();
        @(negedge CLK);
        ack_req = 1'b0;
        checkOutput("tx_valid", 32'(tx_valid), 32'(m_exp.size() != 0));
        checkOutput("busy", 32'(busy), 32'(m_exp.size() != 0));
        if (m_exp.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(m_exp[0]));
        checkOutput("frames_sent", 32'(frames_sent), 32'(m_frames));
    endtask

    logic [7:0]  leds_frame [5];
    logic [7:0]  exp_byte;
    logic [15:0] fs0;
    bit          reached;
    int          pos;

    initial begin
        RST_N    = 1'b0;
        leds     = 8'h00;
        display  = '0;
        ack_req  = 1'b0;
        ack_code = 8'h00;
        tx_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frames", 32'(frames_sent), 32'd0);
        RST_N = 1'b1;

        // single LEDS frame
        leds = 8'h3C;
        repeat (12) applyStimulus();
        leds_frame = '{8'hA5, 8'h01, 8'h01, 8'h3C, 8'h3C};
        checkOutput("leds_frame_len", 32'(tx_log.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < tx_log.size()) checkOutput("leds_frame_byte", 32'(tx_log[k]), 32'(leds_frame[k]));
        end
        checkOutput("leds_idle_busy", 32'(busy), 32'd0);
        checkOutput("leds_frames", 32'(frames_sent), 32'd1);

        // DISPLAY frame with a single non-zero byte at index 9
        tx_log.delete();
        display[9*8 +: 8] = 8'h3F;
        repeat (75) applyStimulus();
        checkOutput("disp_frame_len", 32'(tx_log.size()), 32'(DB + FRAME_OVERHEAD));
        for (int k = 0; k < DB + FRAME_OVERHEAD; k++) begin
            if (k == 0)                          exp_byte = 8'hA5;
            else if (k == 1)                     exp_byte = 8'h02;
            else if (k == 2)                     exp_byte = 8'h40;
            else if (k == DB + FRAME_OVERHEAD - 1) exp_byte = 8'h7D;
            else if (k - 3 == 9)                 exp_byte = 8'h3F;
            else                                 exp_byte = 8'h00;
            if (k < tx_log.size()) checkOutput("disp_frame_byte", 32'(tx_log[k]), 32'(exp_byte));
        end
        checkOutput("disp_frames", 32'(frames_sent), 32'd2);

        // ACK, LEDS and DISPLAY requested on the same cycle
        tx_log.delete();
        leds              = 8'h81;
        display[0 +: 8]   = 8'h11;
        ack_code          = 8'h55;
        ack_req           = 1'b1;
        repeat (100) applyStimulus();
        checkOutput("prio_total_len", 32'(tx_log.size()), 32'(5 + 5 + DB + FRAME_OVERHEAD));
        if (tx_log.size() >= 12) begin
            checkOutput("prio_first_id", 32'(tx_log[1]), 32'h03);
            checkOutput("prio_ack_code", 32'(tx_log[3]), 32'h55);
            checkOutput("prio_ack_csum", 32'(tx_log[4]), 32'h57);
            checkOutput("prio_second_id", 32'(tx_log[6]), 32'h01);
            checkOutput("prio_leds_val", 32'(tx_log[8]), 32'h81);
            checkOutput("prio_third_id", 32'(tx_log[11]), 32'h02);
        end

        // quiet window of four refresh periods: two frames per period
        fs0 = frames_sent;
        repeat (4 * REFRESH) applyStimulus();
        checkOutput("refresh_frames", 32'(16'(frames_sent - fs0)), 32'd8);

        // random traffic with a stuttering transmitter
        for (int c = 0; c < 3000; c++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) leds = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                pos = $urandom_range(0, DB - 1);
                display[pos*8 +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 59) == 0) begin
                ack_req  = 1'b1;
                ack_code = 8'($urandom);
            end
            applyStimulus();
        end

        tx_ready = 1'b1;
        repeat (200) applyStimulus();

        // asynchronous reset in the middle of a display payload
        display[5*8 +: 8] = display[5*8 +: 8] ^ 8'hFF;
        reached = 1'b0;
        for (int c = 0; c < 300 && !reached; c++) begin
            applyStimulus();
            if (m_cur_id == ID_DISPLAY_DEF && m_exp.size() > 5 && m_exp.size() < 60) reached = 1'b1;
        end
        checkOutput("reach_disp_payload", 32'(reached), 32'd1);
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("midrst_frames", 32'(frames_sent), 32'd0);
        model_reset();
        tx_log.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (100) applyStimulus();
        checkOutput("postrst_has_frame", 32'(tx_log.size() >= 5), 32'd1);
        if (tx_log.size() > 0) checkOutput("postrst_first_sync", 32'(tx_log[0]), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
